// File: rtl/mod503_chunk_reducer.sv
// Reduces a wide unsigned operand modulo MOD by walking 6-bit chunks LSB-first
// through one shared residue LUT port and accumulating the returned residues.
module mod503_chunk_reducer #(
    parameter int WIDTH = 36,
    parameter int MOD = 503,
    localparam int NCHUNK = (WIDTH + 5) / 6,
    localparam int SELW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [SELW-1:0]  lut_sel,
    output logic [5:0]       lut_x,
    input  logic [8:0]       lut_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8:0]       out_data,
    output logic             out_err
);

    localparam int PW = 6 * NCHUNK;
    localparam logic [9:0] MOD10 = 10'(MOD);
    localparam logic [SELW-1:0] KLAST = SELW'(NCHUNK - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid, once raised, holds with stable data until that edge.
    logic [1:0]      state;
    logic [PW-1:0]   opnd;
    logic [SELW-1:0] k;
    logic [8:0]      acc;
    logic            err;

    logic [9:0] sum;
    logic [8:0] acc_next;
    logic       z_bad;

    always_comb begin
        sum      = {1'b0, acc} + {1'b0, lut_z};
        acc_next = (sum >= MOD10) ? 9'(sum - MOD10) : sum[8:0];
        z_bad    = ({1'b0, lut_z} >= MOD10);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            opnd  <= '0;
            k     <= '0;
            acc   <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opnd  <= PW'(in_data);
                        acc   <= '0;
                        k     <= '0;
                        err   <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // The operand register shifts so the current chunk is always in the low bits.
                    opnd <= opnd >> 6;
                    acc  <= acc_next;
                    err  <= err | z_bad;
                    if (k == KLAST) begin
                        state <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = acc;
    assign out_err   = err;
    assign lut_sel   = (state == RUN) ? k : '0;
    assign lut_x     = (state == RUN) ? opnd[5:0] : 6'd0;

endmodule

// File: tb/tb_mod503_chunk_reducer.sv
// Directed and random checks of mod503_chunk_reducer against a behavioural
// residue LUT and a scoreboard of expected {err, residue} results.
module tb_mod503_chunk_reducer;

    localparam int WIDTH = 36;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic [2:0]        lut_sel;
    logic [5:0]        lut_x;
    logic [8:0]        lut_z;
    logic              out_valid;
    logic              out_ready;
    logic [8:0]        out_data;
    logic              out_err;
    logic              inject;

    int compared = 0;
    int mismatched = 0;
    logic [9:0] exp_q[$];

    mod503_chunk_reducer #(.WIDTH(WIDTH), .MOD(503)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .lut_sel(lut_sel), .lut_x(lut_x), .lut_z(lut_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err)
    );

    always #5 clk = ~clk;

    function automatic longint unsigned lut_ref(input longint unsigned sel, input longint unsigned x);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < int'(sel); i++) p = p * 64;
        return (x * p) % 503;
    endfunction

    always_comb begin
        lut_z = 9'd0;
        if (inject && lut_sel == 3'd2) lut_z = 9'd505;
        else lut_z = 9'(lut_ref(64'(lut_sel), 64'(lut_x)));
    end

    // Adder behaviour when chunk 2 returns the out-of-range value 505.
    function automatic logic [9:0] err_model(input logic [WIDTH-1:0] v);
        longint unsigned a, s, z, x;
        a = 0;
        for (int i = 0; i < 6; i++) begin
            x = (64'(v) >> (6 * i)) & 63;
            z = (i == 2) ? 505 : lut_ref(64'(i), x);
            s = a + z;
            if (s >= 503) s = s - 503;
            a = s & 511;
        end
        return {1'b1, 9'(a)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] v, input bit inj, input int hold);
        logic [9:0] e;
        int cyc;
        bit seen;
        inject = inj;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        e = inj ? err_model(v) : {1'b0, 9'(v % 503)};
        exp_q.push_back(e);
        in_data   = v;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = {4'($urandom_range(15, 0)), $urandom()};
        cyc  = 1;
        seen = 0;
        while (cyc < 20) begin
            if (out_valid) begin
                seen = 1;
                break;
            end
            if (cyc <= 6) begin
                check("lut_sel", 64'(lut_sel), 64'(cyc - 1));
                check("lut_x", 64'(lut_x), (64'(v) >> (6 * (cyc - 1))) & 64'd63);
            end
            @(negedge clk);
            cyc++;
        end
        check("latency", seen ? 64'(cyc) : 64'hffff, 64'd7);
        e = exp_q.pop_front();
        if (seen) begin
            check("out_data", 64'(out_data), 64'(e[8:0]));
            check("out_err", 64'(out_err), 64'(e[9]));
            for (int h = 0; h < hold; h++) begin
                in_valid = 1'b1;
                in_data  = {4'($urandom_range(15, 0)), $urandom()};
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(out_data), 64'(e[8:0]));
                check("hold_err", 64'(out_err), 64'(e[9]));
                check("hold_in_ready", 64'(in_ready), 64'd0);
                @(negedge clk);
            end
            out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            check("post_valid_low", 64'(out_valid), 64'd0);
            check("post_in_ready", 64'(in_ready), 64'd1);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] r;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        inject    = 1'b0;
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        check("rst_lut_sel", 64'(lut_sel), 64'd0);
        check("rst_lut_x", 64'(lut_x), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(36'd1, 0, 0);
        run_op(36'd502, 0, 0);
        run_op(36'd503, 0, 0);
        run_op(36'd1006, 0, 0);
        run_op(36'hF_FFFF_FFFF, 0, 0);
        check("max_const", 64'(36'hF_FFFF_FFFF % 503), 64'd21);
        run_op(36'd502 + 36'd502 * 64, 0, 0);
        check("boundary_const", 64'((36'd502 + 36'd502 * 64) % 503), 64'd438);

        run_op(36'd123456789, 0, 5);
        run_op(36'h9_8765_4321, 1, 0);
        run_op(36'h9_8765_4321, 0, 0);
        run_op(36'd777, 1, 3);
        run_op(36'd777, 0, 0);

        // Abort an operation part way through RUN.
        inject   = 1'b0;
        in_data  = 36'h1_2345_6789;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_out_data", 64'(out_data), 64'd0);
        check("abort_out_err", 64'(out_err), 64'd0);
        check("abort_lut_sel", 64'(lut_sel), 64'd0);
        check("abort_lut_x", 64'(lut_x), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("after_abort_valid", 64'(out_valid), 64'd0);
            check("after_abort_ready", 64'(in_ready), 64'd1);
        end
        run_op(36'd1006, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            r = {4'($urandom_range(15, 0)), $urandom()};
            run_op(r, 0, (i % 50 == 0) ? int'($urandom_range(3, 1)) : 0);
        end

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
